dual_mode_queue: RTL and testbench

Parametrised successor to the team's 8-entry shifting queue: a circular-buffer data queue of configurable width and depth that runs as FIFO or LIFO, uses every slot, and accepts simultaneous enqueue and dequeue in one cycle. It sits between a producer and a consumer that each issue single-cycle requests. Its outputs are occupancy count, registered read data with a valid strobe, and sticky overflow/underflow error flags.

---
 rtl/dual_mode_queue_if.sv | 28 ++
 rtl/dual_mode_queue.sv | 86 ++++++++
 tb/tb_dual_mode_queue.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dual_mode_queue_if.sv
// dual_mode_queue_if: producer/consumer request bus and status outputs of the dual-mode queue
interface dual_mode_queue_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
);
    logic              mode;
    logic              enqueue;
    logic              dequeue;
    logic              clear_err;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              valid_out;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output mode, enqueue, dequeue, clear_err, data_in,
        input  data_out, valid_out, empty, full, count, overflow, underflow
    );

    modport slave (
        input  mode, enqueue, dequeue, clear_err, data_in,
        output data_out, valid_out, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/dual_mode_queue.sv
// dual_mode_queue: circular-buffer queue running as FIFO or LIFO, all slots usable,
// registered pop data with valid strobe and sticky overflow/underflow flags
module dual_mode_queue #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    dual_mode_queue_if.slave   bus
);
    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W-1:0] P_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   C_ONE = (ADDR_W+1)'(1);

    logic [WIDTH-1:0]  r_mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_mode_q;
    logic [WIDTH-1:0]  r_data_out;
    logic              r_valid;
    logic              r_ovf;
    logic              r_unf;

    logic              w_em;
    logic              w_pop;
    logic              w_push;
    logic              w_lifo_pop;
    logic [ADDR_W-1:0] w_top;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_wr_nxt;
    logic [ADDR_W-1:0] w_rd_nxt;
    logic [ADDR_W:0]   w_count_nxt;

    // LIFO pop with push replaces the top in place, so the write goes to wr_ptr-1
    always_comb begin
        w_em        = (r_count == '0) ? bus.mode : r_mode_q;
        w_pop       = bus.dequeue && (r_count != '0);
        w_push      = bus.enqueue && ((r_count != DEPTH) || w_pop);
        w_lifo_pop  = w_em && w_pop;
        w_top       = r_wr_ptr - P_ONE;
        w_rd_addr   = w_em ? w_top : r_rd_ptr;
        w_wr_addr   = w_lifo_pop ? w_top : r_wr_ptr;
        w_count_nxt = (w_push && !w_pop) ? r_count + C_ONE :
                      (w_pop && !w_push) ? r_count - C_ONE : r_count;
        w_wr_nxt    = (w_em && w_count_nxt == '0)  ? '0 :
                      (w_push && !w_lifo_pop)      ? r_wr_ptr + P_ONE :
                      (w_lifo_pop && !w_push)      ? w_top : r_wr_ptr;
        w_rd_nxt    = w_em ? '0 : w_pop ? r_rd_ptr + P_ONE : r_rd_ptr;
    end

    always_ff @(posedge clock) begin
        if (w_push && reset) r_mem[w_wr_addr] <= bus.data_in;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_mode_q   <= 1'b0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_rd_ptr   <= w_rd_nxt;
            r_wr_ptr   <= w_wr_nxt;
            r_count    <= w_count_nxt;
            r_mode_q   <= w_em;
            r_valid    <= w_pop;
            if (w_pop) r_data_out <= r_mem[w_rd_addr];
            r_ovf      <= (bus.enqueue && !w_push) || (r_ovf && !bus.clear_err);
            r_unf      <= (bus.dequeue && !w_pop) || (r_unf && !bus.clear_err);
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid;
    assign bus.count     = r_count;
    assign bus.empty     = (r_count == '0);
    assign bus.full      = (r_count == DEPTH);
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
endmodule

// File: tb/tb_dual_mode_queue.sv
// tb_dual_mode_queue: queue-content model plus pop scoreboard against dual_mode_queue
module tb_dual_mode_queue;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dual_mode_queue_if #(.WIDTH(32), .ADDR_W(3)) bus ();

    dual_mode_queue #(.WIDTH(32), .ADDR_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_q[$];
    logic [31:0] sb[$];
    bit          m_mode_q, m_ovf, m_unf, m_valid;
    logic [31:0] m_dout;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic compare_outputs();
        check("count", 32'(bus.count), m_q.size());
        check("empty", 32'(bus.empty), 32'(m_q.size() == 0));
        check("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("underflow", 32'(bus.underflow), 32'(m_unf));
        check("valid_out", 32'(bus.valid_out), 32'(m_valid));
        check("data_out", bus.data_out, m_dout);
        if (bus.valid_out) begin
            if (sb.size() == 0) check("sb_empty", 32'(bus.valid_out), 0);
            else check("sb_data", bus.data_out, sb.pop_front());
        end
    endtask

    task automatic step(input bit en, input bit de, input logic [31:0] din, input bit md, input bit clr);
        bit em, pop, push;
        logic [31:0] v;
        em   = (m_q.size() == 0) ? md : m_mode_q;
        pop  = de && m_q.size() != 0;
        push = en && (m_q.size() != DEPTH || pop);
        if (pop) begin
            v = em ? m_q[$] : m_q[0];
            if (em) void'(m_q.pop_back());
            else void'(m_q.pop_front());
            sb.push_back(v);
            m_dout = v;
        end
        if (push) m_q.push_back(din);
        m_ovf    = (en && !push) || (m_ovf && !clr);
        m_unf    = (de && !pop) || (m_unf && !clr);
        m_valid  = pop;
        m_mode_q = em;
        bus.enqueue   = en;
        bus.dequeue   = de;
        bus.data_in   = din;
        bus.mode      = md;
        bus.clear_err = clr;
        @(posedge clock);
        #1;
        bus.enqueue   = 1'b0;
        bus.dequeue   = 1'b0;
        bus.clear_err = 1'b0;
        compare_outputs();
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        bus.enqueue = 1'b1;
        bus.dequeue = 1'b1;
        bus.data_in = 32'hDEAD;
        @(posedge clock);
        #1;
        reset       = 1'b1;
        bus.enqueue = 1'b0;
        bus.dequeue = 1'b0;
        m_q.delete();
        sb.delete();
        m_mode_q = 0;
        m_dout   = '0;
        m_ovf    = 0;
        m_unf    = 0;
        m_valid  = 0;
        compare_outputs();
    endtask

    initial begin
        bus.mode = 0; bus.enqueue = 0; bus.dequeue = 0; bus.clear_err = 0; bus.data_in = '0;
        do_reset();
        // FIFO fill, overflow, drain
        for (int i = 1; i <= 8; i++) step(1, 0, 32'(i), 0, 0);
        check("fifo_full", 32'(bus.full), 1);
        step(1, 0, 32'd9, 0, 0);
        check("fifo_ovf", 32'(bus.overflow), 1);
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 0);
        check("fifo_last", bus.data_out, 32'd8);
        step(0, 0, '0, 0, 1);
        // LIFO order and underflow hold
        step(1, 0, 32'hA, 1, 0);
        step(1, 0, 32'hB, 1, 0);
        step(1, 0, 32'hC, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, '0, 1, 0);
        check("lifo_hold", bus.data_out, 32'hA);
        step(0, 0, '0, 0, 1);
        // simultaneous FIFO
        for (int i = 1; i <= 3; i++) step(1, 0, 32'(i), 0, 0);
        step(1, 1, 32'd4, 0, 0);
        check("fifo_both", bus.data_out, 32'd1);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0, 0);
        // simultaneous LIFO
        step(1, 0, 32'd5, 1, 0);
        step(1, 0, 32'd6, 1, 0);
        step(1, 1, 32'd7, 1, 0);
        check("lifo_both", bus.data_out, 32'd6);
        step(0, 1, '0, 1, 0);
        step(0, 1, '0, 1, 0);
        check("lifo_after", bus.data_out, 32'd5);
        // full plus both in FIFO
        for (int i = 0; i < 8; i++) step(1, 0, 32'h10 + 32'(i), 0, 0);
        step(1, 1, 32'h99, 0, 0);
        check("full_both", bus.data_out, 32'h10);
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 0);
        // empty plus both
        step(1, 1, 32'h55, 0, 0);
        step(0, 1, '0, 0, 1);
        // mode change ignored while non-empty
        step(1, 0, 32'd21, 0, 0);
        step(1, 0, 32'd22, 0, 0);
        step(0, 1, '0, 1, 0);
        step(0, 1, '0, 1, 0);
        step(1, 0, 32'd23, 1, 0);
        step(1, 0, 32'd24, 1, 0);
        step(0, 1, '0, 1, 0);
        step(0, 1, '0, 1, 0);
        // reset mid-operation
        for (int i = 0; i < 5; i++) step(1, 0, 32'h30 + 32'(i), 0, 0);
        do_reset();
        // new error wins over clear_err
        for (int i = 0; i < 8; i++) step(1, 0, 32'(i), 0, 0);
        step(1, 0, 32'hEE, 0, 0);
        step(1, 0, 32'hEF, 0, 1);
        step(0, 0, '0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
        check("sb_left", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
